// File: rtl/inv_subbytes_iter.sv
// Iterative AES InvSubBytes engine: substitutes BPC bytes of a 128-bit state per
// clock through the inverse S-box, with valid/ready handshakes on input and output.
module inv_subbytes_iter #(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N  = 16 / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [127:0]  st, st_next;
  logic [7:0]    sub_in  [BPC];
  logic [7:0]    sub_out [BPC];

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, which maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b[i] = s[(i + 2) % 8] ^ s[(i + 5) % 8] ^ s[(i + 7) % 8];
    end
    return gf_inv(b ^ 8'h05);
  endfunction

  // Route the byte group selected by cnt into the BPC shared lookups
  always_comb begin
    for (int b = 0; b < BPC; b++) begin
      sub_in[b] = 8'h00;
      for (int g = 0; g < N; g++) begin
        if (int'(cnt) == g) sub_in[b] = st[127 - 8 * (g * BPC + b) -: 8];
      end
      sub_out[b] = inv_sbox(sub_in[b]);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    st_next    = st;
    case (state)
      IDLE: begin
        if (in_valid) begin
          st_next    = in_data;
          cnt_next   = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < 16; j++) begin
          if (int'(cnt) == j / BPC) st_next[127 - 8 * j -: 8] = sub_out[j % BPC];
        end
        if (cnt == CW'(N - 1)) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      st    <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      st    <= st_next;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign out_data  = st;

endmodule

// File: doc/inv_subbytes_iter.md
# inv_subbytes_iter

Iterative AES InvSubBytes engine for the decryption datapath. It accepts a 128-bit AES state over a valid/ready handshake and substitutes every byte through the FIPS-197 inverse S-box, processing `BPC` bytes per clock. It returns the result over a second valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the inverse cipher and trades area for latency by instantiating only `BPC` inverse S-box lookups.

## Interface
- `BPC`, default 4: bytes substituted per busy cycle. Legal values are 1, 2, 4, 8, 16. Busy cycles per block `N = 16/BPC`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: engine can accept a block (high only in IDLE).
- `in_data` input 128: state to substitute. Byte 0 = `in_data[127:120]` … byte 15 = `in_data[7:0]`.
- `out_valid` output 1: `out_data` holds a finished block.
- `out_ready` input 1: consumer accepts `out_data`.
- `out_data` output 128: substituted state, same byte order as `in_data`.
- `busy` output 1: high in BUSY state.

## Operation
- Per-byte function: `out_byte = InvSbox(in_byte)`, exactly the inverse of the AES forward S-box. Examples:
  - InvSbox(63)=00, InvSbox(7c)=01, InvSbox(00)=52, InvSbox(01)=09, InvSbox(ed)=53, InvSbox(16)=ff.
  - Implementation may be a 256-entry case table or inverse-affine followed by GF(2^8) inversion (poly 0x11b). It must be bit-exact for all 256 inputs.
- Internal 128-bit state register and byte-group counter `cnt` (width ceil(log2(N)), minimum 1 bit).
- States:
  - **IDLE**: `in_ready=1`. On `in_valid&&in_ready`: capture `in_data` into the state register, `cnt<=0`, go to BUSY.
  - **BUSY**: each cycle, replace bytes `cnt*BPC .. cnt*BPC+BPC-1` of the state register with their InvSbox values, then `cnt<=cnt+1`. On the cycle `cnt==N-1`, go to DONE. The counter wraps to 0 and is never read outside BUSY.
  - **DONE**: `out_valid=1`, and `out_data` shows the state register. On `out_ready`, go to IDLE.
- `in_data` is sampled only at the accept edge. Later changes to `in_data` have no effect.
- `in_valid` in BUSY or DONE is ignored (`in_ready=0`). Back-to-back blocks do not overlap.
- `out_ready` outside DONE is ignored.
- `out_data` is held stable throughout DONE while `out_ready` is low. Outside DONE it shows the state register, which includes partially substituted content during BUSY, and consumers must not use it.
- Reset, including mid-BUSY or mid-DONE: the block in flight is discarded with no output.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, `cnt=0`, state register=0, `in_ready=1`, `out_valid=0`, `busy=0`, `out_data=0`.
- `in_ready`, `out_valid` and `busy` are decoded from the registered state only. There are no combinational input-to-output paths.
- Accept at edge k → BUSY during cycles k+1…k+N → `out_valid` rises after edge k+N (latency N cycles, e.g. 4 for `BPC=4`, 16 for `BPC=1`, 1 for `BPC=16`).
- Output handshake at edge m (`out_valid&&out_ready`) → `in_ready` high after edge m. The earliest next accept is edge m+1.
- Peak throughput is one block per N+2 cycles, reached with `in_valid` and `out_ready` tied high.
- Reset deasserting with `in_valid` high: accept occurs on the first rising edge after deassertion.

## Test plan
- **Known vector, BPC=4:** `in_data`=637c777bf26b6fc53001672bfed7ab76, `out_ready`=1 → `out_valid` exactly 4 cycles after accept, `out_data`=000102030405060708090a0b0c0d0e0f, `in_ready` returns 1 cycle later.
- **Uniform blocks:** all-00 → all-52; all-16 → all-ff; all-63 → all-00. Check for `BPC` = 1, 2, 8, 16 with latencies 16, 8, 2, 1.
- **Exhaustive byte check:** feed blocks covering all 256 byte values. Apply the forward AES S-box to `out_data` in the bench and require the original input back for every byte.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE → `out_valid` stays 1, `out_data` is unchanged, `in_ready`=0 throughout, and a toggling `in_valid`/`in_data` is ignored. Release → one transfer only.
- **Reset mid-BUSY:** assert `reset` on the 2nd BUSY cycle → immediately `out_valid`=0, `in_ready`=1, `out_data`=0. A fresh block accepted after release produces only its own correct result.
- **Input stability:** change `in_data` every cycle during BUSY → result reflects only the value captured at the accept edge.
